// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
//   Detects a run-time programmable PAT_LEN-bit serial pattern on a
//   valid-qualified bit stream. Overlapping or non-overlapping detection is
//   selected at configuration time. Produces a registered one-cycle match
//   pulse and a saturating match counter.
//
//   Optional feature, enabled by defining SEQ_DET_MASK_EN:
//     adds a cfg_mask port (loaded with cfg_load, reset value 0); any mask
//     bit set to 1 is don't-care in the pattern compare. When the macro is
//     undefined the port is absent and the compare is exact.
module seq_pattern_detector #(
  parameter int                 PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] PAT_DEFAULT = 4'b1011,
  parameter int                 CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_LEN-1:0] cfg_mask,
`endif
  input  logic               count_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_LEN-1:0] pattern_q;
  logic               overlap_q;
  logic [PAT_LEN-1:0] window_q;
  logic [FILL_W-1:0]  fill_q;
  logic [PAT_LEN-1:0] mask_eff;

  logic               accept;
  logic [PAT_LEN-1:0] window_next;
  logic [FILL_W-1:0]  fill_next;
  logic               hit;

`ifdef SEQ_DET_MASK_EN
  logic [PAT_LEN-1:0] mask_q;
  assign mask_eff = mask_q;
`else
  // Without the mask feature every pattern bit takes part in the compare.
  assign mask_eff = '0;
`endif

  // Next window/fill for an accepted beat and the resulting hit decision.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    accept      = 1'b0;
    window_next = window_q;
    fill_next   = fill_q;
    hit         = 1'b0;

    // A beat presented together with cfg_load is discarded.
    accept      = in_valid && !cfg_load;
    window_next = {window_q[PAT_LEN-2:0], in_bit};
    fill_next   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

    hit = accept && (fill_next == FILL_FULL) &&
          (((window_next ^ pattern_q) & ~mask_eff) == '0);
  end

  // Configuration, shift window, fill tracking, match pulse and counter.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      pattern_q   <= PAT_DEFAULT;
      overlap_q   <= 1'b1;
      window_q    <= '0;
      fill_q      <= '0;
      match       <= 1'b0;
      match_count <= '0;
`ifdef SEQ_DET_MASK_EN
      mask_q      <= '0;
`endif
    end else begin
      if (cfg_load) begin
        pattern_q <= cfg_pattern;
        overlap_q <= cfg_overlap;
`ifdef SEQ_DET_MASK_EN
        mask_q    <= cfg_mask;
`endif
        window_q  <= '0;
        fill_q    <= '0;
        match     <= 1'b0;
      end else if (accept) begin
        window_q <= window_next;
        // Non-overlap mode restarts the fill so the next match needs a
        // completely fresh pattern's worth of bits.
        fill_q   <= (hit && !overlap_q) ? '0 : fill_next;
        match    <= hit;
      end else begin
        match    <= 1'b0;
      end

      // Clear has priority over a coincident hit; the pulse still fires.
      if (count_clr) begin
        match_count <= '0;
      end else if (hit && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector
//   Directed bench for seq_pattern_detector (default parameters). The mask
//   scenario is compiled in only when SEQ_DET_MASK_EN is defined.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
`ifdef SEQ_DET_MASK_EN
  logic [3:0] cfg_mask;
`endif
  logic       count_clr;
  logic       match;
  logic [7:0] match_count;

  int vectors = 0;
  int errors  = 0;
  int hits;

  seq_pattern_detector #(
    .PAT_LEN    (4),
    .PAT_DEFAULT(4'b1011),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask   (cfg_mask),
`endif
    .count_clr  (count_clr),
    .match      (match),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
  task automatic beat(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  // Load a configuration; optionally clear the counter and offer a beat
  // that must be discarded.
  task automatic cfg(input logic [3:0] pat, input logic ov, input logic [3:0] msk,
                     input logic clr, input logic v, input logic b);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_overlap = ov;
`ifdef SEQ_DET_MASK_EN
    cfg_mask    = msk;
`else
    if (msk != 4'b0000) $display("note: mask ignored in this build");
`endif
    count_clr   = clr;
    beat(v, b);
    cfg_load    = 1'b0;
    count_clr   = 1'b0;
  endtask

  // Stream n valid bits (MSB first) and check match after each one.
  task automatic stream(input string tag, input logic [15:0] bits,
                        input logic [15:0] exp, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      beat(1'b1, bits[i]);
      check($sformatf("%s_bit%0d", tag, n - i), {31'd0, match}, {31'd0, exp[i]});
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 4'b0000; cfg_overlap = 1'b0; count_clr = 1'b0;
`ifdef SEQ_DET_MASK_EN
    cfg_mask = 4'b0000;
`endif
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    check("reset_match", {31'd0, match}, 32'd0);
    check("reset_count", {24'd0, match_count}, 32'd0);
    reset = 1'b0;

    // Default pattern 1011 straight out of reset.
    stream("basic", 16'b1011, 16'b0001, 4);
    check("basic_count", {24'd0, match_count}, 32'd1);
    beat(1'b0, 1'b0);
    check("basic_pulse_end", {31'd0, match}, 32'd0);

    // Overlapping detection: hits after bits 4 and 7.
    cfg(4'b1011, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("ovl_cfg_count", {24'd0, match_count}, 32'd0);
    stream("ovl", 16'b1011011, 16'b0001001, 7);
    check("ovl_count", {24'd0, match_count}, 32'd2);

    // Non-overlapping: only the first hit.
    cfg(4'b1011, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    stream("novl", 16'b1011011, 16'b0001000, 7);
    check("novl_count", {24'd0, match_count}, 32'd1);

    // Idle gaps carrying misleading bits must be ignored.
    cfg(4'b1011, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1); check("gap_b1", {31'd0, match}, 32'd0);
    beat(1'b0, 1'b1); check("gap_i1", {31'd0, match}, 32'd0);
    beat(1'b1, 1'b0); check("gap_b2", {31'd0, match}, 32'd0);
    beat(1'b0, 1'b0); check("gap_i2", {31'd0, match}, 32'd0);
    beat(1'b0, 1'b1); check("gap_i3", {31'd0, match}, 32'd0);
    beat(1'b1, 1'b1); check("gap_b3", {31'd0, match}, 32'd0);
    beat(1'b0, 1'b0); check("gap_i4", {31'd0, match}, 32'd0);
    beat(1'b1, 1'b1); check("gap_b4", {31'd0, match}, 32'd1);
    beat(1'b0, 1'b1); check("gap_after", {31'd0, match}, 32'd0);
    check("gap_count", {24'd0, match_count}, 32'd1);

    // Counter saturation: 1011 followed by 259 repeats of 011 = 260 hits.
    cfg(4'b1011, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    hits = 0;
    beat(1'b1, 1'b1); beat(1'b1, 1'b0); beat(1'b1, 1'b1);
    beat(1'b1, 1'b1); if (match) hits++;
    for (int k = 0; k < 259; k++) begin
      beat(1'b1, 1'b0); if (match) hits++;
      beat(1'b1, 1'b1); if (match) hits++;
      beat(1'b1, 1'b1); if (match) hits++;
    end
    check("sat_pulses", hits, 32'd260);
    check("sat_count", {24'd0, match_count}, 32'd255);

    // count_clr coinciding with a hit: clear wins, pulse still fires.
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b1);
    count_clr = 1'b1;
    beat(1'b1, 1'b1);
    count_clr = 1'b0;
    check("clr_hit_match", {31'd0, match}, 32'd1);
    check("clr_hit_count", {24'd0, match_count}, 32'd0);
    stream("clr_next", 16'b011, 16'b001, 3);
    check("clr_next_count", {24'd0, match_count}, 32'd1);

    // cfg_load mid-pattern restarts fill; the coincident beat is dropped.
    cfg(4'b1011, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    stream("restart_pre", 16'b101, 16'b000, 3);
    cfg(4'b1011, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    check("restart_cfg_match", {31'd0, match}, 32'd0);
    stream("restart", 16'b1011, 16'b0001, 4);
    check("restart_count", {24'd0, match_count}, 32'd1);

    // Reset mid-pattern, then confirm default pattern and overlap return.
    cfg(4'b1101, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    stream("rst_pre", 16'b110, 16'b000, 3);
    reset = 1'b1;
    beat(1'b1, 1'b1);
    reset = 1'b0;
    check("rst_mid_match", {31'd0, match}, 32'd0);
    check("rst_mid_count", {24'd0, match_count}, 32'd0);
    stream("rst_post", 16'b1011011, 16'b0001001, 7);
    check("rst_post_count", {24'd0, match_count}, 32'd2);

`ifdef SEQ_DET_MASK_EN
    // Bit 2 masked: 1111 matches pattern 1011.
    cfg(4'b1011, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    stream("mask", 16'b1111, 16'b0001, 4);
    check("mask_count", {24'd0, match_count}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
